bus_burst_addr_gen: RTL

//  Burst-to-beat address generator on the request path of the 32-bit bus fabric.

---
 rtl/bus_burst_addr_gen.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bus_burst_addr_gen.sv
// Burst-to-beat address generator: takes one FIXED/INCR/WRAP descriptor and
// emits one beat per cycle with address, byte-lane mask, index and last flag.
module bus_burst_addr_gen #(
   parameter int AW   = 32,
   parameter int DBW  = 4,
   parameter int IDW  = 4,
   parameter int SZW  = 3,
   parameter int LENW = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [IDW-1:0]  req_id_i,
   input  logic [AW-1:0]   req_addr_i,
   input  logic [LENW-1:0] req_len_i,
   input  logic [SZW-1:0]  req_size_i,
   input  logic [1:0]      req_burst_i,
   output logic            beat_valid_o,
   input  logic            beat_ready_i,
   output logic [IDW-1:0]  beat_id_o,
   output logic [AW-1:0]   beat_addr_o,
   output logic [DBW-1:0]  beat_mask_o,
   output logic [LENW-1:0] beat_idx_o,
   output logic            beat_last_o,
   output logic            busy_o,
   output logic            err_o
);
   localparam int LW        = $clog2(DBW);
   localparam int PAGE_BITS = 12;

   typedef enum logic {IDLE, ACTIVE} state_t;

   typedef struct packed {
      logic [IDW-1:0]  id;
      logic [LENW-1:0] len;
      logic [SZW-1:0]  size;
      logic [1:0]      burst;
   } desc_t;

   state_t          state_q, state_nx;
   desc_t           desc_q;
   logic [AW-1:0]   addr_q, wrap_q, addr_nx;
   logic [LENW-1:0] idx_q;
   logic            ready_q, err_q, ready_nx, err_nx;
   logic            accept, legal, hs, last;

   logic [AW-1:0]   in_bytes, in_align, in_total, in_last;
   logic [AW-1:0]   cur_bytes, cur_align;
   logic [LW-1:0]   hi_lane;
   logic [DBW-1:0]  mask_raw;

   // Legality of the descriptor on the request port, evaluated on the accept edge.
   // The page check only needs bits above PAGE_BITS, so AW-bit modular sums suffice.
   always_comb begin
      in_bytes = AW'(1) << req_size_i;
      in_align = req_addr_i & ~(in_bytes - AW'(1));
      in_total = (AW'(req_len_i) + AW'(1)) << req_size_i;
      in_last  = in_align + in_total - AW'(1);
      legal    = 1'b1;
      if (req_size_i > SZW'(LW)) legal = 1'b0;
      if (req_burst_i == 2'd3) legal = 1'b0;
      if (req_burst_i == 2'd2) begin
         if (!(req_len_i == LENW'(1) || req_len_i == LENW'(3) ||
               req_len_i == LENW'(7) || req_len_i == LENW'(15))) legal = 1'b0;
         if ((req_addr_i & (in_bytes - AW'(1))) != '0) legal = 1'b0;
      end
      if (req_burst_i == 2'd1 && ((in_last ^ req_addr_i) >> PAGE_BITS) != '0) legal = 1'b0;
   end

   // Beat datapath: next address and lane range of the current beat.
   always_comb begin
      cur_bytes = AW'(1) << desc_q.size;
      cur_align = addr_q & ~(cur_bytes - AW'(1));
      hi_lane   = cur_align[LW-1:0] + cur_bytes[LW-1:0] - LW'(1);
      case (desc_q.burst)
         2'd0:    addr_nx = addr_q;
         2'd2:    addr_nx = (addr_q & ~wrap_q) | ((addr_q + cur_bytes) & wrap_q);
         default: addr_nx = cur_align + cur_bytes;
      endcase
   end

   for (genvar i = 0; i < DBW; i++) begin : g_lane
      assign mask_raw[i] = (LW'(i) >= addr_q[LW-1:0]) && (LW'(i) <= hi_lane);
   end

   always_comb begin
      state_nx = state_q;
      accept   = 1'b0;
      hs       = 1'b0;
      last     = (idx_q == desc_q.len);
      case (state_q)
         IDLE: begin
            accept = req_valid_i & ready_q;
            if (accept && legal) state_nx = ACTIVE;
         end
         ACTIVE: begin
            hs = beat_ready_i;
            if (hs && last) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      ready_nx = (state_nx == IDLE);
      err_nx   = accept & ~legal;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_nx;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         desc_q  <= '0;
         addr_q  <= '0;
         wrap_q  <= '0;
         idx_q   <= '0;
      end else begin
         ready_q <= ready_nx;
         err_q   <= err_nx;
         if (accept && legal) begin
            desc_q <= '{id: req_id_i, len: req_len_i, size: req_size_i, burst: req_burst_i};
            addr_q <= req_addr_i;
            wrap_q <= in_total - AW'(1);
            idx_q  <= '0;
         end else if (hs && !last) begin
            addr_q <= addr_nx;
            idx_q  <= idx_q + LENW'(1);
         end
      end
   end

   assign req_ready_o  = ready_q;
   assign err_o        = err_q;
   assign beat_valid_o = (state_q == ACTIVE);
   assign busy_o       = (state_q == ACTIVE);
   assign beat_id_o    = desc_q.id;
   assign beat_addr_o  = addr_q;
   assign beat_idx_o   = idx_q;
   assign beat_mask_o  = beat_valid_o ? mask_raw : '0;
   assign beat_last_o  = beat_valid_o & last;
endmodule
